ieeedrv_sd_arb: RTL

IEEEDRV_SD_ARB -- requirements
Module: ieeedrv_sd_arb

---
 rtl/ieeedrv_sd_arb.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ieeedrv_sd_arb.sv
// ieeedrv_sd_arb
// Round-robin arbiter that lets up to four requesters share one SD block
// request port. One requester owns the host port at a time; its LBA and block
// count are captured when the command is issued, and the host acknowledge and
// buffer-write strobe are routed back to that owner only.
//
// Ports
//   i_clk_sys       system clock, all logic on the rising edge
//   i_reset         synchronous active-high reset
//   i_req_lba       per-requester start LBA
//   i_req_blk_cnt   per-requester block count minus one
//   i_req_rd/wr     per-requester level read/write requests
//   o_req_ack       sd_ack routed to the current owner
//   o_req_err       one-cycle timeout pulse to the current owner
//   o_sd_lba/blk_cnt/rd/wr  shared host request port (registered)
//   i_sd_ack        host acknowledge, high for the whole transfer
//   i_sd_buff_wr    host buffer-write strobe
//   o_req_buff_wr   buffer-write strobe routed to the current owner
//   o_grant         index of the current owner
//   o_grant_vld     o_grant is valid
module ieeedrv_sd_arb #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TO_BITS = 24
) (
    input  logic            i_clk_sys,
    input  logic            i_reset,
    input  logic [31:0]     i_req_lba     [NREQ],
    input  logic [5:0]      i_req_blk_cnt [NREQ],
    input  logic [NREQ-1:0] i_req_rd,
    input  logic [NREQ-1:0] i_req_wr,
    output logic [NREQ-1:0] o_req_ack,
    output logic [NREQ-1:0] o_req_err,
    output logic [31:0]     o_sd_lba,
    output logic [5:0]      o_sd_blk_cnt,
    output logic            o_sd_rd,
    output logic            o_sd_wr,
    input  logic            i_sd_ack,
    input  logic            i_sd_buff_wr,
    output logic [NREQ-1:0] o_req_buff_wr,
    output logic [1:0]      o_grant,
    output logic            o_grant_vld
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StXfer,
        StDone
    } state_e;

    // Last count value before the counter wraps to all-ones; reaching all-ones
    // on this edge is the timeout.
    localparam logic [TO_BITS-1:0] ToLast = ~TO_BITS'(1);

    state_e             r_state;
    logic [1:0]         r_grant;
    logic               r_grant_vld;
    logic [1:0]         r_rr_ptr;
    logic [TO_BITS-1:0] r_to_cnt;
    logic [NREQ-1:0]    r_req_err;
    logic [31:0]        r_sd_lba;
    logic [5:0]         r_sd_blk_cnt;
    logic               r_sd_rd;
    logic               r_sd_wr;

    // Requester inputs padded to four entries so a 2-bit index is always legal.
    logic [3:0]  w_rd4;
    logic [3:0]  w_wr4;
    logic [3:0]  w_pend4;
    logic [31:0] w_lba4 [4];
    logic [5:0]  w_blk4 [4];

    always_comb begin
        w_rd4 = '0;
        w_wr4 = '0;
        for (int k = 0; k < 4; k++) begin
            w_lba4[k] = '0;
            w_blk4[k] = '0;
        end
        for (int k = 0; k < int'(NREQ); k++) begin
            w_rd4[k]  = i_req_rd[k];
            w_wr4[k]  = i_req_wr[k];
            w_lba4[k] = i_req_lba[k];
            w_blk4[k] = i_req_blk_cnt[k];
        end
    end

    assign w_pend4 = w_rd4 | w_wr4;

    // First pending requester searching upward from r_rr_ptr with wrap.
    logic [1:0] w_pick;
    logic [1:0] w_idx;
    logic       w_any;

    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        w_any  = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_idx = 2'((int'(r_rr_ptr) + k) % int'(NREQ));
            if (!w_any && w_pend4[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    logic            w_g_rd;
    logic            w_g_wr;
    logic [1:0]      w_next_ptr;
    logic [NREQ-1:0] w_grant_oh;

    assign w_g_rd     = w_rd4[r_grant];
    assign w_g_wr     = w_wr4[r_grant];
    assign w_next_ptr = 2'((int'(r_grant) + 1) % int'(NREQ));

    // Owner one-hot is qualified by grant_vld so a stale ack in IDLE goes nowhere.
    always_comb begin
        w_grant_oh = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_grant_oh[k] = r_grant_vld && (r_grant == 2'(k));
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_grant_vld  <= 1'b0;
            r_rr_ptr     <= '0;
            r_to_cnt     <= '0;
            r_req_err    <= '0;
            r_sd_lba     <= '0;
            r_sd_blk_cnt <= '0;
            r_sd_rd      <= 1'b0;
            r_sd_wr      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_grant     <= w_pick;
                        r_grant_vld <= 1'b1;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    r_to_cnt <= '0;
                    if (w_g_wr || w_g_rd) begin
                        r_sd_lba     <= w_lba4[r_grant];
                        r_sd_blk_cnt <= w_blk4[r_grant];
                        // Write wins when both directions are requested.
                        r_sd_wr      <= w_g_wr;
                        r_sd_rd      <= !w_g_wr;
                        r_state      <= StWaitAck;
                    end else begin
                        // Requester withdrew before issue: release without a host request.
                        r_state <= StDone;
                    end
                end
                StWaitAck: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (i_sd_ack) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_state <= StXfer;
                    end else if (r_to_cnt == ToLast) begin
                        r_sd_rd   <= 1'b0;
                        r_sd_wr   <= 1'b0;
                        r_req_err <= w_grant_oh;
                        r_state   <= StDone;
                    end
                end
                StXfer: begin
                    if (!i_sd_ack) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_rr_ptr    <= w_next_ptr;
                    r_grant_vld <= 1'b0;
                    r_req_err   <= '0;
                    r_state     <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_req_ack     = w_grant_oh & {NREQ{i_sd_ack}};
    assign o_req_buff_wr = w_grant_oh & {NREQ{i_sd_buff_wr}};
    assign o_req_err     = r_req_err;
    assign o_sd_lba      = r_sd_lba;
    assign o_sd_blk_cnt  = r_sd_blk_cnt;
    assign o_sd_rd       = r_sd_rd;
    assign o_sd_wr       = r_sd_wr;
    assign o_grant       = r_grant;
    assign o_grant_vld   = r_grant_vld;

endmodule
